// File: rtl/cpu_step_sched.sv
// CPU step/run scheduler: issues one-clk cpu_tick pulses for single-step or
// free-run operation, with memory settle time, run-rate pacing and a PC breakpoint.
module cpu_step_sched #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned RATE_W     = 24
) (
  input  logic              clk,
  input  logic              rst_cpu,
  input  logic              step_req,
  input  logic              run_en,
  input  logic              brk_en,
  input  logic [8:0]        brk_pc,
  input  logic [8:0]        pc,
  input  logic [RATE_W-1:0] run_period,
  output logic              cpu_tick,
  output logic              busy,
  output logic              brk_hit,
  output logic [2:0]        state,
  output logic [15:0]       tick_cnt
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_TICK   = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_BRK    = 3'd4
  } state_e;

  // Last settle count value; a zero settle parameter degenerates to one cycle.
  localparam logic [RATE_W-1:0] SETTLE_LAST = RATE_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
  // Shortest legal tick-to-tick interval.
  localparam logic [RATE_W-1:0] MIN_I       = RATE_W'(SETTLE_CYC + 2);

  state_e            st_n;
  logic [RATE_W-1:0] cnt_q;
  logic [RATE_W-1:0] cnt_n;
  logic [RATE_W-1:0] wait_load;

  // WAIT length minus one, from the clamped interval: I - SETTLE_CYC - 2.
  assign wait_load = (run_period < MIN_I) ? '0 : (run_period - MIN_I);

  // Next-state and phase counter logic.
  always_comb begin
    st_n  = S_HALT;
    cnt_n = '0;
    case (state)
      S_HALT: begin
        if (step_req || run_en) st_n = S_TICK;
        else                    st_n = S_HALT;
      end
      S_TICK: begin
        st_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          if (!run_en)                         st_n = S_HALT;
          else if (brk_en && (pc == brk_pc))   st_n = S_BRK;
          else begin
            st_n  = S_WAIT;
            cnt_n = wait_load;
          end
        end else begin
          st_n  = S_SETTLE;
          cnt_n = cnt_q + RATE_W'(1);
        end
      end
      S_WAIT: begin
        if (!run_en)              st_n = S_HALT;
        else if (cnt_q == '0)     st_n = S_TICK;
        else begin
          st_n  = S_WAIT;
          cnt_n = cnt_q - RATE_W'(1);
        end
      end
      S_BRK: begin
        if (step_req)     st_n = S_TICK;
        else if (!run_en) st_n = S_HALT;
        else              st_n = S_BRK;
      end
      default: st_n = S_HALT;
    endcase
  end

  // State, counters and outputs decoded from the next state so they are registered.
  always_ff @(posedge clk or posedge rst_cpu) begin
    if (rst_cpu) begin
      state    <= S_HALT;
      cnt_q    <= '0;
      cpu_tick <= 1'b0;
      busy     <= 1'b0;
      brk_hit  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      state    <= st_n;
      cnt_q    <= cnt_n;
      cpu_tick <= (st_n == S_TICK);
      busy     <= (st_n == S_TICK) || (st_n == S_SETTLE) || (st_n == S_WAIT);
      brk_hit  <= (st_n == S_BRK);
      if (st_n == S_TICK) tick_cnt <= tick_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_step_sched.sv
// Self-checking bench for cpu_step_sched (SETTLE_CYC=2).
module tb_cpu_step_sched;

  localparam int unsigned S  = 2;
  localparam int unsigned RW = 24;

  logic          clk = 1'b0;
  logic          rst_cpu = 1'b1;
  logic          step_req = 1'b0;
  logic          run_en = 1'b0;
  logic          brk_en = 1'b0;
  logic [8:0]    brk_pc = '0;
  logic [8:0]    pc;
  logic [RW-1:0] run_period = '0;
  logic          cpu_tick, busy, brk_hit;
  logic [2:0]    state;
  logic [15:0]   tick_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          tick_t[$];
  logic [15:0] exp_cnt = '0;

  cpu_step_sched #(.SETTLE_CYC(S), .RATE_W(RW)) dut (
    .clk(clk), .rst_cpu(rst_cpu), .step_req(step_req), .run_en(run_en),
    .brk_en(brk_en), .brk_pc(brk_pc), .pc(pc), .run_period(run_period),
    .cpu_tick(cpu_tick), .busy(busy), .brk_hit(brk_hit), .state(state),
    .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  // Log the cycle at which each tick is consumed by the CPU.
  always @(posedge clk) begin
    if (cpu_tick) tick_t.push_back(cyc);
    cyc <= cyc + 1;
  end

  // PC register model advanced by the tick.
  always @(posedge clk or posedge rst_cpu) begin
    if (rst_cpu)       pc <= '0;
    else if (cpu_tick) pc <= pc + 9'd1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic int exp_interval(input int p);
    return (p < int'(S + 2)) ? int'(S + 2) : p;
  endfunction

  task automatic adv(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (state == s) begin ok = 1'b1; break; end
      adv(1);
    end
  endtask

  task automatic wait_ticks(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (tick_t.size() >= n) begin ok = 1'b1; break; end
      adv(1);
    end
  endtask

  task automatic stop_run();
    bit ok;
    run_en = 1'b0;
    wait_state(3'd0, 64, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stop_run: got state %0d want 0", state); end
  endtask

  task automatic test_reset();
    rst_cpu = 1'b1;
    adv(2);
    n_cmp++; if (state !== 3'd0)     begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (cpu_tick !== 1'b0)  begin n_bad++; $display("FAIL rst_tick: got %0b want 0", cpu_tick); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if (brk_hit !== 1'b0)   begin n_bad++; $display("FAIL rst_brk: got %0b want 0", brk_hit); end
    n_cmp++; if (tick_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", tick_cnt); end
    rst_cpu = 1'b0;
    exp_cnt = '0;
    adv(2);
  endtask

  task automatic test_single_step();
    logic [2:0] es[4];
    logic       eb[4];
    es = '{3'd1, 3'd2, 3'd2, 3'd0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b0};
    tick_t.delete();
    step_req = 1'b1;
    adv(1);
    step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL step_state[%0d]: got %0d want %0d", i, state, es[i]); end
      n_cmp++; if (busy !== eb[i])  begin n_bad++; $display("FAIL step_busy[%0d]: got %0b want %0b", i, busy, eb[i]); end
      n_cmp++; if (cpu_tick !== (i == 0)) begin n_bad++; $display("FAIL step_tick[%0d]: got %0b want %0b", i, cpu_tick, (i == 0)); end
      adv(1);
    end
    adv(2);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (tick_cnt !== exp_cnt)  begin n_bad++; $display("FAIL step_cnt: got %0d want %0d", tick_cnt, exp_cnt); end
    n_cmp++; if (tick_t.size() != 1)    begin n_bad++; $display("FAIL step_ntick: got %0d want 1", tick_t.size()); end
  endtask

  task automatic test_run_rate(input int p);
    bit ok;
    int c0, ii, n1;
    ii = exp_interval(p);
    tick_t.delete();
    run_period = RW'(p);
    c0 = cyc;
    run_en = 1'b1;
    wait_ticks(5, 5 * ii + 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rate_run p=%0d: got %0d ticks want 5", p, tick_t.size()); end
    if (tick_t.size() >= 5) begin
      n_cmp++; if (tick_t[0] != c0 + 1) begin n_bad++; $display("FAIL rate_first p=%0d: got cycle %0d want %0d", p, tick_t[0], c0 + 1); end
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (tick_t[i] - tick_t[i-1] != ii) begin
          n_bad++; $display("FAIL rate_interval p=%0d #%0d: got %0d want %0d", p, i, tick_t[i] - tick_t[i-1], ii);
        end
      end
    end
    wait_state(3'd3, ii + 4, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rate_wait p=%0d: got state %0d want 3", p, state); end
    run_en = 1'b0;
    n1 = tick_t.size();
    adv(2 * ii + 4);
    n_cmp++; if (state !== 3'd0)      begin n_bad++; $display("FAIL rate_halt p=%0d: got %0d want 0", p, state); end
    n_cmp++; if (tick_t.size() != n1) begin n_bad++; $display("FAIL rate_notick p=%0d: got %0d want %0d", p, tick_t.size(), n1); end
    exp_cnt = exp_cnt + 16'(tick_t.size());
    n_cmp++; if (tick_cnt !== exp_cnt) begin n_bad++; $display("FAIL rate_cnt p=%0d: got %0d want %0d", p, tick_cnt, exp_cnt); end
  endtask

  task automatic test_ignored_step();
    int p, ii;
    tick_t.delete();
    step_req = 1'b1;
    adv(1);
    adv(3);
    step_req = 1'b0;
    adv(4);
    n_cmp++; if (tick_t.size() != 1) begin n_bad++; $display("FAIL ign_halt: got %0d ticks want 1", tick_t.size()); end
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (tick_cnt !== exp_cnt) begin n_bad++; $display("FAIL ign_halt_cnt: got %0d want %0d", tick_cnt, exp_cnt); end
    p = $urandom_range(4, 12);
    ii = exp_interval(p);
    run_period = RW'(p);
    tick_t.delete();
    run_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step_req = (state >= 3'd1 && state <= 3'd3) ? 1'($urandom % 2) : 1'b0;
      adv(1);
    end
    step_req = 1'b0;
    stop_run();
    adv(2);
    for (int i = 1; i < tick_t.size(); i++) begin
      n_cmp++;
      if (tick_t[i] - tick_t[i-1] != ii) begin
        n_bad++; $display("FAIL ign_interval #%0d: got %0d want %0d", i, tick_t[i] - tick_t[i-1], ii);
      end
    end
    exp_cnt = exp_cnt + 16'(tick_t.size());
    n_cmp++; if (tick_cnt !== exp_cnt) begin n_bad++; $display("FAIL ign_run_cnt: got %0d want %0d", tick_cnt, exp_cnt); end
  endtask

  task automatic test_breakpoint();
    bit ok;
    int p, ii, c0;
    rst_cpu = 1'b1;
    adv(1);
    rst_cpu = 1'b0;
    exp_cnt = '0;
    adv(1);
    p = $urandom_range(0, 9);
    ii = exp_interval(p);
    run_period = RW'(p);
    brk_pc = 9'd5;
    brk_en = 1'b1;
    tick_t.delete();
    run_en = 1'b1;
    wait_state(3'd4, 200, ok);
    n_cmp++; if (!ok)                  begin n_bad++; $display("FAIL brk_reach: got state %0d want 4", state); end
    n_cmp++; if (tick_t.size() != 5)   begin n_bad++; $display("FAIL brk_nticks: got %0d want 5", tick_t.size()); end
    n_cmp++; if (brk_hit !== 1'b1)     begin n_bad++; $display("FAIL brk_hit: got %0b want 1", brk_hit); end
    n_cmp++; if (pc !== 9'd5)          begin n_bad++; $display("FAIL brk_pc: got %0d want 5", pc); end
    n_cmp++; if (tick_cnt !== 16'd5)   begin n_bad++; $display("FAIL brk_cnt: got %0d want 5", tick_cnt); end
    adv($urandom_range(2, 6));
    n_cmp++; if (state !== 3'd4)       begin n_bad++; $display("FAIL brk_hold: got %0d want 4", state); end
    n_cmp++; if (tick_t.size() != 5)   begin n_bad++; $display("FAIL brk_hold_ticks: got %0d want 5", tick_t.size()); end
    c0 = cyc;
    step_req = 1'b1;
    adv(1);
    step_req = 1'b0;
    wait_ticks(8, 8 * ii + 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL brk_resume: got %0d ticks want 8", tick_t.size()); end
    if (tick_t.size() >= 7) begin
      n_cmp++; if (tick_t[5] != c0 + 1) begin n_bad++; $display("FAIL brk_step_time: got %0d want %0d", tick_t[5], c0 + 1); end
      n_cmp++; if (tick_t[6] - tick_t[5] != ii) begin n_bad++; $display("FAIL brk_resume_int: got %0d want %0d", tick_t[6] - tick_t[5], ii); end
    end
    n_cmp++; if (brk_hit !== 1'b0) begin n_bad++; $display("FAIL brk_clear: got %0b want 0", brk_hit); end
    stop_run();
    brk_en = 1'b0;
    adv(2);
    exp_cnt = 16'(tick_t.size());
    n_cmp++; if (tick_cnt !== exp_cnt) begin n_bad++; $display("FAIL brk_total: got %0d want %0d", tick_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    force dut.tick_cnt = 16'hFFFE;
    #1;
    release dut.tick_cnt;
    adv(1);
    step_req = 1'b1;
    adv(1);
    step_req = 1'b0;
    n_cmp++; if (tick_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre: got %0h want ffff", tick_cnt); end
    adv(4);
    step_req = 1'b1;
    adv(1);
    step_req = 1'b0;
    n_cmp++; if (tick_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap: got %0h want 0", tick_cnt); end
    adv(4);
  endtask

  task automatic test_async_reset();
    bit ok;
    int c0;
    run_period = RW'($urandom_range(8, 15));
    run_en = 1'b1;
    wait_state(3'd3, 40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ar_wait: got state %0d want 3", state); end
    #2;
    rst_cpu = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0)     begin n_bad++; $display("FAIL ar_state: got %0d want 0", state); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL ar_busy: got %0b want 0", busy); end
    n_cmp++; if (cpu_tick !== 1'b0)  begin n_bad++; $display("FAIL ar_tick: got %0b want 0", cpu_tick); end
    n_cmp++; if (brk_hit !== 1'b0)   begin n_bad++; $display("FAIL ar_brk: got %0b want 0", brk_hit); end
    n_cmp++; if (tick_cnt !== 16'd0) begin n_bad++; $display("FAIL ar_cnt: got %0d want 0", tick_cnt); end
    run_en = 1'b0;
    adv(1);
    #2;
    rst_cpu = 1'b0;
    tick_t.delete();
    adv(10);
    n_cmp++; if (tick_t.size() != 0) begin n_bad++; $display("FAIL ar_notick: got %0d want 0", tick_t.size()); end
    n_cmp++; if (state !== 3'd0)     begin n_bad++; $display("FAIL ar_idle: got %0d want 0", state); end
    rst_cpu = 1'b1;
    run_en = 1'b1;
    adv(1);
    #2;
    rst_cpu = 1'b0;
    c0 = cyc;
    tick_t.delete();
    wait_ticks(1, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ar_first: got %0d ticks want 1", tick_t.size()); end
    if (tick_t.size() >= 1) begin
      n_cmp++; if (tick_t[0] != c0 + 1) begin n_bad++; $display("FAIL ar_first_time: got %0d want %0d", tick_t[0], c0 + 1); end
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_run_rate(10);
    test_run_rate(0);
    test_run_rate(1);
    repeat (3) test_run_rate($urandom_range(2, 20));
    test_ignored_step();
    test_breakpoint();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_step_sched.md
CPU_STEP_SCHED -- requirements
Module: cpu_step_sched

Interface
REQ-001 Parameter SETTLE_CYC, default 2: clk cycles after each tick for synchronous instruction/data memories to settle.
REQ-002 Parameter RATE_W, default 24: width of run_period.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_cpu  input  1  reset, asynchronous, active-high.
REQ-005 step_req  input  1  debounced single-cycle pulse: request one CPU cycle.
REQ-006 run_en  input  1  level: free-run the CPU.
REQ-007 brk_en  input  1  level: enable PC breakpoint.
REQ-008 brk_pc  input  9  breakpoint word address.
REQ-009 pc  input  9  current PC from PC register.
REQ-010 run_period  input  RATE_W  requested tick-to-tick interval in clk cycles while running.
REQ-011 cpu_tick  output  1  one-clk-wide enable pulse advancing PC, register file and data memory.
REQ-012 busy  output  1  high in TICK, SETTLE, WAIT.
REQ-013 brk_hit  output  1  high while in BRK.
REQ-014 state  output  3  encoded FSM state for display.
REQ-015 tick_cnt  output  16  count of issued ticks.

Function
REQ-016 States and encodings: HALT=0, TICK=1, SETTLE=2, WAIT=3, BRK=4; other codes go to HALT next cycle.
REQ-017 HALT: cpu_tick=0; step_req or run_en -> TICK; otherwise stay.
REQ-018 TICK: lasts exactly one cycle; cpu_tick=1; tick_cnt increments, 16'hFFFF wraps to 0; next SETTLE.
REQ-019 SETTLE: lasts exactly SETTLE_CYC cycles, then: run_en=0 -> HALT; run_en=1 and brk_en=1 and pc==brk_pc -> BRK; else WAIT.
REQ-020 Breakpoint compare uses pc sampled in last SETTLE cycle (post-tick PC).
REQ-021 WAIT: lasts W = I-1-SETTLE_CYC cycles, where I = max(run_period, SETTLE_CYC+2); then TICK; run_en=0 in any WAIT cycle -> HALT next cycle, no tick.
REQ-022 Consequence: running tick-to-tick interval is exactly I clk cycles; run_period=0 or 1 yields I=SETTLE_CYC+2.
REQ-023 run_period sampled on entry to WAIT; changes mid-WAIT take effect next interval.
REQ-024 BRK: brk_hit=1; step_req -> TICK (steps past breakpoint; run resumes if run_en still 1); else run_en=0 -> HALT; else stay.
REQ-025 step_req ignored in TICK, SETTLE, WAIT; never queued.
REQ-026 step_req and run_en both high in HALT -> single TICK; subsequent behaviour per run_en.
REQ-027 brk_en=0 disables compare; brk_en change mid-run evaluated only at SETTLE exit.
REQ-028 Only one cpu_tick per TICK entry; no two ticks less than SETTLE_CYC+2 cycles apart.
REQ-029 busy, brk_hit, state, cpu_tick registered (glitch-free, direct FSM decode of registered state).

Reset
REQ-030 rst_cpu=1 forces immediately: state=HALT, cpu_tick=0, busy=0, brk_hit=0, tick_cnt=0, internal counters=0.
REQ-031 rst_cpu asserted mid-TICK/SETTLE/WAIT aborts sequence; no tick issued after release until new step_req or run_en.
REQ-032 After rst_cpu release with run_en=1, first cpu_tick on second rising edge (HALT->TICK).

Verification (SETTLE_CYC=2)
REQ-033 Single step: HALT, one step_req pulse -> one cpu_tick next cycle, tick_cnt=1, state 1->2->2->0, busy high 3 cycles.
REQ-034 Run rate: run_en=1, run_period=10 -> cpu_tick every 10 clk; run_period=0 -> every 4 clk; drop run_en in WAIT -> no further tick, HALT.
REQ-035 Breakpoint: run_en=1, brk_en=1, brk_pc=5, pc incrementing from 0 -> exactly 5 ticks, BRK, brk_hit=1; step_req -> 6th tick, running resumes.
REQ-036 Ignored step: step_req pulses during SETTLE and WAIT -> no extra ticks, tick_cnt unchanged by them.
REQ-037 Wrap: preload via 65535 ticks, one more tick -> tick_cnt=0.
REQ-038 Async reset: rst_cpu pulse mid-WAIT (between clock edges) -> outputs cleared before next edge, state=0, tick_cnt=0.
